// File: rtl/memory_responder.sv
// Single-ported word memory that answers every accepted request with exactly one
// registered response. Optional address range checking: MEMORY_RESPONDER_RANGE_CHECK_EN.
module memory_responder #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        hart_to_memory_controller_valid,
  input  logic [31:0] hart_to_memory_controller_address,
  input  logic        hart_to_memory_controller_write,
  input  logic [31:0] hart_to_memory_controller_write_data,
  output logic        hart_to_memory_controller_ready,
  input  logic        memory_controller_to_hart_ready,
  output logic        memory_controller_to_hart_valid,
  output logic [31:0] memory_controller_to_hart_read_data,
  output logic        memory_controller_to_hart_error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic {IDLE, RESPOND} state_t;

  req_t          req;
  state_t        state, state_nx;
  logic          resp_valid, resp_ready, req_ready, accept, bad;
  logic [AW-1:0] idx;
  logic [31:0]   rdata;
  logic          rerr;
  logic [31:0]   mem [DEPTH_WORDS];

  assign req.valid  = hart_to_memory_controller_valid;
  assign req.write  = hart_to_memory_controller_write;
  assign req.addr   = hart_to_memory_controller_address;
  assign req.wdata  = hart_to_memory_controller_write_data;
  assign resp_ready = memory_controller_to_hart_ready;

  assign idx = req.addr[AW+1:2];

`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
  assign bad = (|req.addr[1:0]) | (|req.addr[31:AW+2]);
`else
  // Upper bits are dropped so the index wraps modulo DEPTH_WORDS.
  logic unused_hi;
  assign unused_hi = ^req.addr[31:AW+2];
  assign bad       = |req.addr[1:0];
`endif

  assign resp_valid = (state == RESPOND);
  assign req_ready  = !resp_valid | resp_ready;
  assign accept     = req.valid & req_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RESPOND;
      RESPOND: if (accept) state_nx = RESPOND;
               else if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      rdata <= '0;
      rerr  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rerr  <= bad;
        rdata <= (!req.write && !bad) ? mem[idx] : '0;
      end
    end
  end

  // Storage has no reset; writes are blocked while reset is held.
  always_ff @(posedge clock) begin
    if (accept && req.write && !bad && clear_n)
      mem[idx] <= req.wdata;
  end

  assign hart_to_memory_controller_ready      = req_ready;
  assign memory_controller_to_hart_valid      = resp_valid;
  assign memory_controller_to_hart_read_data  = rdata;
  assign memory_controller_to_hart_error      = rerr;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: directed vector table, stall/reset sequences and a
// random stream, all checked through an in-order expected-response queue.
module tb_memory_responder;

  localparam int DEPTH = 1024;
`ifdef MEMORY_RESPONDER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear_n;
  logic        req_valid, req_write, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        resp_ready, resp_valid, resp_err;
  logic [31:0] resp_data;

  memory_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .hart_to_memory_controller_valid      (req_valid),
    .hart_to_memory_controller_address    (req_addr),
    .hart_to_memory_controller_write      (req_write),
    .hart_to_memory_controller_write_data (req_wdata),
    .hart_to_memory_controller_ready      (req_ready),
    .memory_controller_to_hart_ready      (resp_ready),
    .memory_controller_to_hart_valid      (resp_valid),
    .memory_controller_to_hart_read_data  (resp_data),
    .memory_controller_to_hart_error      (resp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          v;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    bit          rr;
    bit          eerr;
    logic [31:0] edata;
  } vec_t;

  typedef struct {
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  vec_t        tbl[$];
  logic [31:0] mdl [DEPTH];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_acc = 0;

  function automatic vec_t mk(bit v, bit w, logic [31:0] a, logic [31:0] d, bit rr,
                              bit eerr, logic [31:0] edata);
    vec_t t;
    t.v = v; t.w = w; t.a = a; t.d = d; t.rr = rr; t.eerr = eerr; t.edata = edata;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, check the held response, then track accept.
  task automatic cycle(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit rr, input bit use_tbl, input bit terr, input logic [31:0] tdata);
    bit   acc, merr;
    exp_t e;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; resp_ready = rr;
    #1;
    acc = v && (q.size() == 0 || rr);
    chk("req_ready", 32'(req_ready), 32'((q.size() == 0) || rr));
    chk("resp_valid", 32'(resp_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("read_data", resp_data, q[0].data);
      chk("error", 32'(resp_err), 32'(q[0].err));
      if (rr) void'(q.pop_front());
    end
    if (acc) begin
      merr = (a[1:0] != 2'b00) || (RC && a >= DEPTH * 4);
      e.err  = merr;
      e.data = (!w && !merr) ? mdl[a[11:2]] : 32'h0;
      if (w && !merr) mdl[a[11:2]] = d;
      if (use_tbl) begin
        e.err  = terr;
        e.data = tdata;
      end
      q.push_back(e);
      n_acc++;
    end
    @(posedge clock); #1;
  endtask

  initial begin
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    clear_n = 0;
    #12;
    chk("reset resp_valid", 32'(resp_valid), 32'h0);
    chk("reset read_data", resp_data, 32'h0);
    chk("reset error", 32'(resp_err), 32'h0);
    chk("reset req_ready", 32'(req_ready), 32'h1);
    @(posedge clock); #1;
    clear_n = 1;

    // Directed table, back-to-back with resp_ready held high.
    tbl.push_back(mk(1, 1, 32'h10,   32'hDEADBEEF, 1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h10,   32'h0,        1, 0, 32'hDEADBEEF));
    tbl.push_back(mk(1, 0, 32'h13,   32'h0,        1, 1, 32'h0));
    tbl.push_back(mk(1, 0, 32'h10,   32'h0,        1, 0, 32'hDEADBEEF));
    tbl.push_back(mk(1, 1, 32'h12,   32'h1234,     1, 1, 32'h0));
    tbl.push_back(mk(0, 1, 32'h10,   32'h0,        1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h10,   32'h0,        1, 0, 32'hDEADBEEF));
    tbl.push_back(mk(1, 1, 32'h0,    32'h11112222, 1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h1000, 32'h0,        1, RC, RC ? 32'h0 : 32'h11112222));
    tbl.push_back(mk(1, 1, 32'hFFC,  32'h00000077, 1, 0, 32'h0));
    tbl.push_back(mk(1, 0, 32'hFFC,  32'h0,        1, 0, 32'h00000077));
    tbl.push_back(mk(1, 0, 32'h1FFC, 32'h0,        1, RC, RC ? 32'h0 : 32'h00000077));
    tbl.push_back(mk(1, 0, 32'h0,    32'h0,        1, 0, 32'h11112222));
    for (int i = 0; i < tbl.size(); i++)
      cycle(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rr, 1'b1, tbl[i].eerr, tbl[i].edata);

    // Stall: response must hold and req_ready stay low for 5 cycles.
    cycle(1, 0, 32'h10, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 32'h0, 0, 0, 0, 0, 0);
    cycle(1, 0, 32'h0, 0, 1, 0, 0, 0);
    cycle(1, 0, 32'h10, 0, 1, 0, 0, 0);
    cycle(0, 0, 32'h0, 0, 0, 0, 0, 0);

    // Reset mid-RESPOND with a write presented across the reset edge.
    req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'h0BAD0BAD; resp_ready = 0;
    #1;
    chk("pre-reset resp_valid", 32'(resp_valid), 32'h1);
    clear_n = 0;
    #1;
    chk("async resp_valid", 32'(resp_valid), 32'h0);
    chk("async read_data", resp_data, 32'h0);
    chk("async error", 32'(resp_err), 32'h0);
    chk("async req_ready", 32'(req_ready), 32'h1);
    q.delete();
    @(posedge clock); #1;
    clear_n = 1; req_valid = 0;
    cycle(1, 0, 32'h10, 0, 1, 0, 0, 0);
    cycle(1, 0, 32'h0, 0, 1, 0, 0, 0);

    // Random stream over a preloaded window of words.
    for (int i = 0; i < 16; i++) cycle(1, 1, 32'((32 + i) * 4), $urandom, 1, 0, 0, 0);
    begin
      int start = n_acc;
      int budget = 0;
      while (n_acc - start < 1000 && budget < 6000) begin
        logic [31:0] a;
        a = 32'((32 + $urandom_range(0, 15)) * 4);
        if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom,
              $urandom_range(0, 2) != 0, 0, 0, 0);
        budget++;
      end
      chk("random accepts", 32'(n_acc - start >= 1000), 32'h1);
    end
    for (int i = 0; i < 4 && q.size() != 0; i++) cycle(0, 0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
